// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// The master modport is the environment: the core plus the data memory.
interface load_store_unit_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [2:0] req_rd;

    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic [2:0] resp_rd;
    logic       resp_is_load;
    logic       resp_fault;

    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_write_enable;
    logic [7:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_rd, resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_is_load, resp_fault,
               mem_address, mem_write_data, mem_write_enable
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_rd, resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_data, resp_rd, resp_is_load, resp_fault,
               mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a registered-read data memory,
// with range checking and a saturating count of faulted requests.
module load_store_unit #(
    parameter int BASE_ADDR = 64,
    parameter int DEPTH     = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    load_store_unit_if.slave     bus,
    output logic [7:0]           fault_count
);

    localparam int LAST_ADDR = BASE_ADDR + DEPTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       write_q;

    logic [7:0] resp_data_q;
    logic [2:0] resp_rd_q;
    logic       resp_is_load_q;
    logic       resp_fault_q;

    logic       accept;
    logic       in_range;
    logic       req_ready;
    logic       resp_valid;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_write_enable;

    assign in_range = (int'(bus.req_addr) >= BASE_ADDR) && (int'(bus.req_addr) <= LAST_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory-bus outputs decode from the state register only, so an
    // asynchronous reset removes a pending write strobe without a clock.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next       = state;
        accept           = 1'b0;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_address      = 8'h00;
        mem_write_data   = 8'h00;
        mem_write_enable = 1'b0;

        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = in_range ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                mem_address      = addr_q;
                mem_write_data   = wdata_q;
                mem_write_enable = write_q;
                state_next       = write_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                state_next     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response fields are fixed at acceptance, except load data which
    // arrives from the memory at the end of CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= 8'h00;
            wdata_q        <= 8'h00;
            write_q        <= 1'b0;
            resp_data_q    <= 8'h00;
            resp_rd_q      <= 3'h0;
            resp_is_load_q <= 1'b0;
            resp_fault_q   <= 1'b0;
            fault_count    <= 8'h00;
        end else begin
            if (accept) begin
                addr_q         <= bus.req_addr;
                wdata_q        <= bus.req_wdata;
                write_q        <= bus.req_write;
                resp_data_q    <= 8'h00;
                resp_rd_q      <= bus.req_rd;
                resp_is_load_q <= !bus.req_write;
                resp_fault_q   <= !in_range;
                if (!in_range && fault_count != 8'hFF) begin
                    fault_count <= fault_count + 8'h01;
                end
            end
            if (state == CAPTURE) begin
                resp_data_q <= bus.mem_read_data;
            end
        end
    end

    assign bus.req_ready        = req_ready;
    assign bus.resp_valid       = resp_valid;
    assign bus.resp_data        = resp_data_q;
    assign bus.resp_rd          = resp_rd_q;
    assign bus.resp_is_load     = resp_is_load_q;
    assign bus.resp_fault       = resp_fault_q;
    assign bus.mem_address      = mem_address;
    assign bus.mem_write_data   = mem_write_data;
    assign bus.mem_write_enable = mem_write_enable;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random traffic, checked
// against a request-level model (expected memory image, latency, fault tally).
module tb_load_store_unit;

    localparam int BASE  = 64;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] fault_count;

    load_store_unit_if bus ();

    load_store_unit #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .fault_count (fault_count)
    );

    always #5 clk = ~clk;

    logic [7:0] dmem    [256];
    logic [7:0] ref_mem [256];
    int         n_checks   = 0;
    int         n_errors   = 0;
    int         we_cycles  = 0;
    logic [7:0] we_addr    = 8'h00;
    logic [7:0] we_data    = 8'h00;
    int         ref_faults = 0;

    // Data memory with registered read, as seen by the unit.
    always @(posedge clk) begin
        if (bus.mem_write_enable === 1'b1) dmem[bus.mem_address] <= bus.mem_write_data;
        bus.mem_read_data <= dmem[bus.mem_address];
    end

    // Counts cycles that still carry the write strobe at mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_write_enable === 1'b1) begin
            we_cycles++;
            we_addr = bus.mem_address;
            we_data = bus.mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req();
        bus.req_write = 1'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 8'($urandom);
        bus.req_rd    = 3'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_resp"}, {bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_rd,
                               bus.resp_is_load, bus.resp_fault}, {1'b1, 1'b0, 8'h00, 3'h0, 1'b0, 1'b0});
        check({tag, "_mem"}, {bus.mem_address, bus.mem_write_data, bus.mem_write_enable, fault_count},
              {8'h00, 8'h00, 1'b0, 8'h00});
    endtask

    // Called at a negedge with the unit idle; returns at a negedge, idle again.
    task automatic run_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [2:0] rd, input int hold);
        bit         legal;
        int         exp_lat;
        int         lat;
        int         we0;
        logic [7:0] exp_data;
        legal    = (int'(a) >= BASE) && (int'(a) < BASE + DEPTH);
        exp_lat  = !legal ? 1 : (w ? 2 : 3);
        exp_data = (legal && !w) ? ref_mem[a] : 8'h00;
        we0      = we_cycles;

        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_rd     = rd;
        bus.resp_ready = (hold == 0);
        check("req_ready_idle", bus.req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble_req();

        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("resp_data", bus.resp_data, exp_data);
        check("resp_rd", bus.resp_rd, rd);
        check("resp_is_load", bus.resp_is_load, !w);
        check("resp_fault", bus.resp_fault, !legal);
        if (!legal) ref_faults = (ref_faults < 255) ? ref_faults + 1 : 255;
        check("fault_count", fault_count, ref_faults);

        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            scramble_req();
            @(negedge clk);
            check("resp_hold", {bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_is_load,
                                bus.resp_fault, bus.req_ready}, {1'b1, exp_data, rd, !w, !legal, 1'b0});
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("consumed", {bus.resp_valid, bus.req_ready}, 2'b01);
        bus.req_valid = 1'b0;

        check("we_cycles", we_cycles - we0, (legal && w) ? 1 : 0);
        if (legal && w) begin
            check("we_addr", we_addr, a);
            check("we_data", we_data, d);
            ref_mem[a] = d;
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] edges [4];
        edges = '{8'd63, 8'd64, 8'd127, 8'd128};
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 8'h00;
        bus.req_wdata  = 8'h00;
        bus.req_rd     = 3'h0;
        bus.resp_ready = 1'b0;

        #2;
        check_reset_values("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Store then load back, range boundaries, back-pressure.
        run_req(1'b1, 8'd70, 8'hA5, 3'd2, 0);
        run_req(1'b0, 8'd70, 8'h00, 3'd5, 0);
        run_req(1'b0, 8'd63, 8'h00, 3'd3, 0);
        run_req(1'b1, 8'd128, 8'h11, 3'd4, 0);
        check("fault_count_two", fault_count, 8'd2);
        run_req(1'b0, 8'd127, 8'h00, 3'd6, 0);
        run_req(1'b1, 8'd64, 8'h5A, 3'd7, 0);
        run_req(1'b1, 8'd100, 8'h3C, 3'd1, 5);
        run_req(1'b0, 8'd100, 8'h00, 3'd0, 2);

        // Reset in the middle of a store's ACCESS cycle.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_addr   = 8'd90;
        bus.req_wdata  = ~ref_mem[90];
        bus.req_rd     = 3'd1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("access_we", bus.mem_write_enable, 1'b1);
        check("access_addr", bus.mem_address, 8'd90);
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_store");
        ref_faults = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 8'd90, 8'h00, 3'd3, 0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0:       a = edges[$urandom_range(0, 3)];
                1, 2:    a = 8'($urandom_range(64, 127));
                default: a = 8'($urandom_range(0, 255));
            endcase
            run_req(1'($urandom), a, 8'($urandom), 3'($urandom), $urandom_range(0, 2));
        end

        for (int n = 0; n < 260; n++) begin
            a = $urandom_range(0, 1) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(128, 255));
            run_req(1'($urandom), a, 8'($urandom), 3'($urandom), 0);
        end
        check("fault_count_saturated", fault_count, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
